// File: rtl/fb_swap_ctrl_if.sv
// fb_swap_ctrl_if: framebuffer memory write port with ready/valid handshake.
// addr carries {bank, pixel address}.
interface fb_swap_ctrl_if #(parameter int ADDR_W = 20);
   logic            we;
   logic [ADDR_W:0] addr;
   logic [7:0]      wdata;
   logic            ready;
   modport master (output we, addr, wdata, input ready);
   modport slave  (input we, addr, wdata, output ready);
endinterface

// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: double-buffered framebuffer write controller, buffers pixels and swaps banks on vblank.
// Define FB_MISS_WRITE_EN to write BG_COLOR for miss pixels instead of discarding them.
module fb_swap_ctrl #(
   parameter int         DEPTH    = 16,
   parameter int         ADDR_W   = 20,
   parameter logic [7:0] BG_COLOR = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] fb_addr_w,
   input  logic              hit_w,
   input  logic [7:0]        bri_w,
   input  logic              valid_w,
   input  logic              swap,
   input  logic              vblank,
   fb_swap_ctrl_if.master    mem,
   output logic              disp_bank,
   output logic              frame_done,
   output logic              overflow
);
   localparam int AW = $clog2(DEPTH);
   typedef struct packed {
      logic              mark;
      logic              pix;
      logic              hit;
      logic [7:0]        bri;
      logic [ADDR_W-1:0] addr;
   } entry_t;
   typedef enum logic [1:0] {RUN, DRAIN, WAIT_VB} state_t;
   entry_t          fifo_q [DEPTH];
   entry_t          head, tail;
   logic [AW:0]     rd_q, rd_d, wr_q, wr_d;
   state_t          state_q, state_d;
   logic            out_v_q, out_v_d, bank_q, bank_d, done_q, done_d, ovf_q, ovf_d;
   logic [ADDR_W:0] addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic            empty, full, push, pop, push_ok, head_wr;
   // pix separates real pixels from marker-only entries so a bare swap never writes
   assign head  = fifo_q[rd_q[AW-1:0]];
   assign tail  = '{mark: swap, pix: valid_w, hit: valid_w & hit_w, bri: bri_w, addr: fb_addr_w};
   assign empty = rd_q == wr_q;
   assign full  = (rd_q[AW] != wr_q[AW]) && (rd_q[AW-1:0] == wr_q[AW-1:0]);
   assign push  = valid_w | swap;
`ifdef FB_MISS_WRITE_EN
   assign head_wr = head.pix;
`else
   assign head_wr = head.pix & head.hit;
`endif
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      bank_d  = bank_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      out_v_d = out_v_q & ~mem.ready;
      case (state_q)
         RUN: begin
            pop = !empty && (!out_v_q || mem.ready);
            if (pop && head_wr) begin
               out_v_d = 1'b1;
               addr_d  = {~bank_q, head.addr};
               wdata_d = head.hit ? head.bri : BG_COLOR;
            end
            if (pop && head.mark) state_d = DRAIN;
         end
         DRAIN: state_d = out_v_q ? DRAIN : WAIT_VB;
         WAIT_VB: if (vblank) begin
            bank_d  = ~bank_q;
            done_d  = 1'b1;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      // the pop frees a slot this cycle, so a full FIFO still accepts
      push_ok = push && (!full || pop);
      rd_d    = pop ? rd_q + 1'b1 : rd_q;
      wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
      ovf_d   = ovf_q | (push & ~push_ok);
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= RUN;
         rd_q    <= '0;
         wr_q    <= '0;
         out_v_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         bank_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         out_v_q <= out_v_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         bank_q  <= bank_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push_ok) fifo_q[wr_q[AW-1:0]] <= tail;
   end
   assign mem.we     = out_v_q;
   assign mem.addr   = addr_q;
   assign mem.wdata  = wdata_q;
   assign disp_bank  = bank_q;
   assign frame_done = done_q;
   assign overflow   = ovf_q;
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb_fb_swap_ctrl: directed bench for fb_swap_ctrl with a write log collected from the memory port.
module tb_fb_swap_ctrl;
   localparam int DEPTH = 16;
   logic        clk, reset, hit_w, valid_w, swap, vblank;
   logic [19:0] fb_addr_w;
   logic [7:0]  bri_w;
   logic        disp_bank, frame_done, overflow;
   int          n_chk = 0, n_fail = 0, fd_cnt = 0;
   logic [20:0] log_a [$];
   logic [7:0]  log_d [$];
   fb_swap_ctrl_if #(.ADDR_W(20)) mem_if ();
   fb_swap_ctrl #(.DEPTH(DEPTH), .ADDR_W(20), .BG_COLOR(8'h00)) dut (
      .clk(clk), .reset(reset), .fb_addr_w(fb_addr_w), .hit_w(hit_w), .bri_w(bri_w),
      .valid_w(valid_w), .swap(swap), .vblank(vblank), .mem(mem_if),
      .disp_bank(disp_bank), .frame_done(frame_done), .overflow(overflow)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // inputs only change just after posedge, so negedge sees exactly what the next edge accepts
   always @(negedge clk) begin
      if (mem_if.we && mem_if.ready) begin
         log_a.push_back(mem_if.addr);
         log_d.push_back(mem_if.wdata);
      end
      if (frame_done) fd_cnt++;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic px(input logic [19:0] a, input logic h, input logic [7:0] b, input logic v, input logic s);
      fb_addr_w = a;
      hit_w     = h;
      bri_w     = b;
      valid_w   = v;
      swap      = s;
   endtask
   task automatic idle;
      px(20'h0, 1'b0, 8'h0, 1'b0, 1'b0);
   endtask
   task automatic wait_log(input string tag, input int n, input int budget);
      int k = 0;
      while (log_a.size() < n && k < budget) begin
         tick;
         k++;
      end
      check(tag, log_a.size(), n);
   endtask
   task automatic check_entry(input string tag, input int idx, input logic [20:0] a, input logic [7:0] d);
      if (idx < log_a.size()) begin
         check({tag, "_addr"}, log_a[idx], a);
         check({tag, "_data"}, log_d[idx], d);
      end else check({tag, "_missing"}, idx, log_a.size());
   endtask
   initial begin
      int base, fd0, k;
      reset = 1'b0;
      vblank = 1'b0;
      mem_if.ready = 1'b1;
      idle;
      tick;
      tick;
      check("rst_we", mem_if.we, 0);
      check("rst_addr", mem_if.addr, 0);
      check("rst_wdata", mem_if.wdata, 0);
      check("rst_disp", disp_bank, 0);
      check("rst_done", frame_done, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b1;
      tick;
      // single pixel: visible two edges after it is driven
      base = log_a.size();
      px(20'h00010, 1'b1, 8'h7F, 1'b1, 1'b0);
      tick;
      idle;
      check("single_we_early", mem_if.we, 0);
      tick;
      check("single_we", mem_if.we, 1);
      check("single_addr", mem_if.addr, 21'h100010);
      check("single_data", mem_if.wdata, 8'h7F);
      tick;
      check("single_we_drop", mem_if.we, 0);
      check("single_cnt", log_a.size(), base + 1);
      // backpressure: ready low across edges 1..5
      base = log_a.size();
      mem_if.ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         px(20'h00100 + 20'(i), 1'b1, 8'(i + 1), 1'b1, 1'b0);
         if (i == 5) mem_if.ready = 1'b1;
         tick;
         if (i >= 1 && i <= 4) begin
            check("bp_we", mem_if.we, 1);
            check("bp_addr", mem_if.addr, 21'h100100);
            check("bp_data", mem_if.wdata, 8'h01);
         end
      end
      idle;
      wait_log("bp_cnt", base + 8, 40);
      for (int i = 0; i < 8; i++) check_entry("bp", base + i, 21'h100100 + 21'(i), 8'(i + 1));
      check("bp_ovf", overflow, 0);
      // swap held off by vblank, next-frame pixel waits behind the marker
      base = log_a.size();
      fd0 = fd_cnt;
      for (int i = 0; i < 3; i++) begin
         px(20'h00200 + 20'(i), 1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
         tick;
      end
      px(20'h0, 1'b0, 8'h0, 1'b0, 1'b1);
      tick;
      px(20'h00300, 1'b1, 8'h55, 1'b1, 1'b0);
      tick;
      idle;
      for (int i = 0; i < 10; i++) tick;
      check("swap_cnt", log_a.size(), base + 3);
      for (int i = 0; i < 3; i++) check_entry("swap", base + i, 21'h100200 + 21'(i), 8'h20 + 8'(i));
      check("swap_disp_hold", disp_bank, 0);
      check("swap_fd_hold", fd_cnt, fd0);
      vblank = 1'b1;
      k = 0;
      while (disp_bank !== 1'b1 && k < 5) begin
         tick;
         k++;
      end
      check("swap_disp", disp_bank, 1);
      check("swap_fd_pulse", frame_done, 1);
      vblank = 1'b0;
      wait_log("swap_next_cnt", base + 4, 20);
      check_entry("swap_next", base + 3, 21'h000300, 8'h55);
      check("swap_fd_once", fd_cnt, fd0 + 1);
      // overflow: one in the output register plus DEPTH queued
      base = log_a.size();
      mem_if.ready = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         px(20'h00400 + 20'(i), 1'b1, 8'(i), 1'b1, 1'b0);
         tick;
         if (i == DEPTH) check("ovf_before", overflow, 0);
         if (i == DEPTH + 1) check("ovf_set", overflow, 1);
      end
      idle;
      mem_if.ready = 1'b1;
      for (int i = 0; i < 40; i++) tick;
      check("ovf_cnt", log_a.size(), base + DEPTH + 1);
      for (int i = 0; i < DEPTH + 1; i++) check_entry("ovf", base + i, 21'h000400 + 21'(i), 8'(i));
      check("ovf_sticky", overflow, 1);
      // miss pixel followed by a hit
      base = log_a.size();
      px(20'h00500, 1'b0, 8'h99, 1'b1, 1'b0);
      tick;
      px(20'h00501, 1'b1, 8'h33, 1'b1, 1'b0);
      tick;
      idle;
      for (int i = 0; i < 8; i++) tick;
`ifdef FB_MISS_WRITE_EN
      check("miss_cnt", log_a.size(), base + 2);
      check_entry("miss_bg", base, 21'h000500, 8'h00);
      check_entry("miss_hit", base + 1, 21'h000501, 8'h33);
`else
      check("miss_cnt", log_a.size(), base + 1);
      check_entry("miss_hit", base, 21'h000501, 8'h33);
`endif
      // reset while parked in WAIT_VB with a next-frame pixel queued
      px(20'h00600, 1'b1, 8'h66, 1'b1, 1'b1);
      tick;
      px(20'h00601, 1'b1, 8'h67, 1'b1, 1'b0);
      tick;
      idle;
      for (int i = 0; i < 8; i++) tick;
      check("wvb_disp_before", disp_bank, 1);
      reset = 1'b0;
      tick;
      reset = 1'b1;
      base = log_a.size();
      fd0 = fd_cnt;
      check("wvb_rst_disp", disp_bank, 0);
      check("wvb_rst_ovf", overflow, 0);
      check("wvb_rst_we", mem_if.we, 0);
      vblank = 1'b1;
      for (int i = 0; i < 10; i++) tick;
      vblank = 1'b0;
      check("wvb_no_write", log_a.size(), base);
      check("wvb_no_fd", fd_cnt, fd0);
      check("wvb_disp_after", disp_bank, 0);
      px(20'h00700, 1'b1, 8'h77, 1'b1, 1'b0);
      tick;
      idle;
      wait_log("post_cnt", base + 1, 10);
      check_entry("post", base, 21'h100700, 8'h77);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
